// File: rtl/fmul_result_queue_if.sv
// Valid/ready handshake bundle between the FP multiplier, the result queue and the writeback consumer.
interface fmul_result_queue_if #(
  parameter int WIDTH   = 32,
  parameter int FLAGS_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_r;
  logic [FLAGS_W-1:0] in_flags;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_r;
  logic [FLAGS_W-1:0] out_flags;

  modport master (
    output in_valid, in_r, in_flags, out_ready,
    input  in_ready, out_valid, out_r, out_flags
  );

  modport slave (
    input  in_valid, in_r, in_flags, out_ready,
    output in_ready, out_valid, out_r, out_flags
  );
endinterface

// File: rtl/fmul_result_queue.sv
// Result FIFO behind the FP multiplier with sticky exception-flag accumulation.
// Optional level interrupt on masked sticky flags when FMUL_FLAG_IRQ_EN is defined.
module fmul_result_queue #(
  parameter int WIDTH   = 32,
  parameter int FLAGS_W = 5,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  fmul_result_queue_if.slave       q,
  output logic [FLAGS_W-1:0]       fflags_o,
  input  logic                     fflags_clr_i,
`ifdef FMUL_FLAG_IRQ_EN
  input  logic [FLAGS_W-1:0]       irq_mask_i,
  output logic                     irq_o,
`endif
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH+FLAGS_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [FLAGS_W-1:0]       fflags_q, fflags_d;
  logic                     push_s, pop_s;

  // in_ready looks only at registered occupancy, so a full queue never accepts even while popping
  assign q.in_ready  = ~rst & (count_q != FULL_CNT);
  assign q.out_valid = (count_q != {CW{1'b0}});
  assign push_s      = q.in_valid & q.in_ready;
  assign pop_s       = q.out_valid & q.out_ready;
  assign count_o     = count_q;
  assign fflags_o    = fflags_q;

  // Head word/flags, forced to zero when empty
  always_comb begin
    q.out_r     = {WIDTH{1'b0}};
    q.out_flags = {FLAGS_W{1'b0}};
    if (q.out_valid) begin
      q.out_r     = mem_q[rd_ptr_q][WIDTH+FLAGS_W-1:FLAGS_W];
      q.out_flags = mem_q[rd_ptr_q][FLAGS_W-1:0];
    end else begin
      q.out_r     = {WIDTH{1'b0}};
      q.out_flags = {FLAGS_W{1'b0}};
    end
  end

  // Pointer, occupancy and sticky-flag next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fflags_d = fflags_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case ({fflags_clr_i, push_s})
      2'b11:   fflags_d = q.in_flags;
      2'b10:   fflags_d = {FLAGS_W{1'b0}};
      2'b01:   fflags_d = fflags_q | q.in_flags;
      default: fflags_d = fflags_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      fflags_q <= {FLAGS_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {q.in_r, q.in_flags};
    end
  end

`ifdef FMUL_FLAG_IRQ_EN
  logic irq_q;

  // Level interrupt tracks the flags being written this cycle, not the stale ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(fflags_d & irq_mask_i);
    end
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_fmul_result_queue.sv
// Self-checking bench for fmul_result_queue: vector table, directed reset case, randomized run vs queue model.
module tb_fmul_result_queue;

  logic       clk;
  logic       rst;
  logic [4:0] fflags;
  logic       fflags_clr;
  logic [2:0] count;
`ifdef FMUL_FLAG_IRQ_EN
  logic [4:0] irq_mask;
  logic       irq;
`endif

  int checks = 0;
  int errors = 0;

  fmul_result_queue_if #(.WIDTH(32), .FLAGS_W(5)) bus ();

  fmul_result_queue #(.WIDTH(32), .FLAGS_W(5), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .q            (bus.slave),
    .fflags_o     (fflags),
    .fflags_clr_i (fflags_clr),
`ifdef FMUL_FLAG_IRQ_EN
    .irq_mask_i   (irq_mask),
    .irq_o        (irq),
`endif
    .count_o      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] r;
    logic [4:0]  f;
    logic        ordy;
    logic        clr;
    logic [2:0]  cnt;
    logic        ov;
    logic [31:0] hr;
    logic [4:0]  hf;
    logic [4:0]  ff;
    logic        ir;
  } vec_t;

  vec_t tbl [14];
  logic [36:0] mq [$];
  logic [4:0]  mff;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] f,
                       input logic ordy, input logic clr);
    bus.in_valid  = v;
    bus.in_r      = r;
    bus.in_flags  = f;
    bus.out_ready = ordy;
    fflags_clr    = clr;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
`ifdef FMUL_FLAG_IRQ_EN
    irq_mask = 5'b00000;
`endif

    // expectations are the state seen just after the clock edge that consumes the row's inputs
    tbl[0]  = '{1'b1, 32'h3F800000, 5'b00001, 1'b0, 1'b0, 3'd1, 1'b1, 32'h3F800000, 5'b00001, 5'b00001, 1'b1};
    tbl[1]  = '{1'b1, 32'h40000000, 5'b00100, 1'b0, 1'b0, 3'd2, 1'b1, 32'h3F800000, 5'b00001, 5'b00101, 1'b1};
    tbl[2]  = '{1'b1, 32'h40400000, 5'b00000, 1'b0, 1'b0, 3'd3, 1'b1, 32'h3F800000, 5'b00001, 5'b00101, 1'b1};
    tbl[3]  = '{1'b1, 32'h40800000, 5'b00000, 1'b0, 1'b0, 3'd4, 1'b1, 32'h3F800000, 5'b00001, 5'b00101, 1'b0};
    tbl[4]  = '{1'b1, 32'hDEADBEEF, 5'b00010, 1'b0, 1'b0, 3'd4, 1'b1, 32'h3F800000, 5'b00001, 5'b00101, 1'b0};
    tbl[5]  = '{1'b1, 32'hDEADBEEF, 5'b00010, 1'b1, 1'b0, 3'd3, 1'b1, 32'h40000000, 5'b00100, 5'b00101, 1'b1};
    tbl[6]  = '{1'b1, 32'hDEADBEEF, 5'b00010, 1'b0, 1'b0, 3'd4, 1'b1, 32'h40000000, 5'b00100, 5'b00111, 1'b0};
    tbl[7]  = '{1'b0, 32'h00000000, 5'b00000, 1'b1, 1'b1, 3'd3, 1'b1, 32'h40400000, 5'b00000, 5'b00000, 1'b1};
    tbl[8]  = '{1'b1, 32'h11111111, 5'b10000, 1'b1, 1'b1, 3'd3, 1'b1, 32'h40800000, 5'b00000, 5'b10000, 1'b1};
    tbl[9]  = '{1'b0, 32'h00000000, 5'b00000, 1'b1, 1'b0, 3'd2, 1'b1, 32'hDEADBEEF, 5'b00010, 5'b10000, 1'b1};
    tbl[10] = '{1'b0, 32'h00000000, 5'b00000, 1'b1, 1'b0, 3'd1, 1'b1, 32'h11111111, 5'b10000, 5'b10000, 1'b1};
    tbl[11] = '{1'b0, 32'h00000000, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 32'h00000000, 5'b00000, 5'b10000, 1'b1};
    tbl[12] = '{1'b1, 32'hA5A5A5A5, 5'b01000, 1'b1, 1'b0, 3'd1, 1'b1, 32'hA5A5A5A5, 5'b01000, 5'b11000, 1'b1};
    tbl[13] = '{1'b1, 32'h5A5A5A5A, 5'b00000, 1'b1, 1'b0, 3'd1, 1'b1, 32'h5A5A5A5A, 5'b00000, 5'b11000, 1'b1};

    repeat (3) tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_r", 64'(bus.out_r), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_fflags", 64'(fflags), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].ordy, tbl[i].clr);
      tick();
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].ov));
      chk($sformatf("tbl%0d_out_r", i), 64'(bus.out_r), 64'(tbl[i].hr));
      chk($sformatf("tbl%0d_out_flags", i), 64'(bus.out_flags), 64'(tbl[i].hf));
      chk($sformatf("tbl%0d_fflags", i), 64'(fflags), 64'(tbl[i].ff));
      chk($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].ir));
    end

    // async reset while three entries are queued
    drive(1'b1, 32'hCAFEF00D, 5'b00001, 1'b0, 1'b0);
    tick();
    tick();
    chk("mid_count_before_rst", 64'(count), 64'd3);
    drive(1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_r", 64'(bus.out_r), 64'd0);
    chk("mid_rst_fflags", 64'(fflags), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 32'h12345678, 5'b00000, 1'b0, 1'b0);
    tick();
    chk("after_rst_head", 64'(bus.out_r), 64'h12345678);
    chk("after_rst_count", 64'(count), 64'd1);
    drive(1'b0, 32'h0, 5'h0, 1'b1, 1'b1);
    tick();
    chk("after_rst_drain", 64'(count), 64'd0);

    // randomized run against an ordered-queue model
    mq.delete();
    mff = 5'b00000;
    for (int i = 0; i < 400; i++) begin
      logic v, ordy, clr, push, pop;
      logic [31:0] r;
      logic [4:0]  f;
      chk("rnd_in_ready", 64'(bus.in_ready), 64'(mq.size() != 4));
      chk("rnd_out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      chk("rnd_out_r", 64'(bus.out_r), (mq.size() != 0) ? 64'(mq[0][36:5]) : 64'd0);
      chk("rnd_out_flags", 64'(bus.out_flags), (mq.size() != 0) ? 64'(mq[0][4:0]) : 64'd0);
      chk("rnd_count", 64'(count), 64'(mq.size()));
      chk("rnd_fflags", 64'(fflags), 64'(mff));
      v    = ($urandom_range(0, 99) < 60);
      ordy = ($urandom_range(0, 99) < 50);
      clr  = ($urandom_range(0, 19) == 0);
      r    = $urandom;
      f    = 5'($urandom_range(0, 31));
      drive(v, r, f, ordy, clr);
      push = v && (mq.size() < 4);
      pop  = ordy && (mq.size() > 0);
      if (clr && push) mff = f;
      else if (clr)    mff = 5'b00000;
      else if (push)   mff = mff | f;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({r, f});
      tick();
    end

`ifdef FMUL_FLAG_IRQ_EN
    drive(1'b0, 32'h0, 5'h0, 1'b1, 1'b1);
    irq_mask = 5'b00100;
    repeat (5) tick();
    chk("irq_idle", 64'(irq), 64'd0);
    drive(1'b1, 32'h3F800000, 5'b00100, 1'b1, 1'b0);
    tick();
    chk("irq_set", 64'(irq), 64'd1);
    drive(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);
    tick();
    chk("irq_hold", 64'(irq), 64'd1);
    drive(1'b0, 32'h0, 5'h0, 1'b1, 1'b1);
    tick();
    chk("irq_clear", 64'(irq), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
